// File: rtl/eadd_pkg.sv
// Shared widths and types for the element-wise adder output path.
package eadd_pkg;

  localparam int LANES  = 4;
  localparam int FP32_W = 32;
  localparam int BF16_W = 16;

  localparam logic [6:0] BF16_QNAN_MANT = 7'h40;

  typedef logic [BF16_W-1:0] bf16_t;

endpackage

// File: rtl/bf16_round.sv
// Combinational fp32 -> bf16 lane conversion with canonical quiet NaN.
// Define EADD_PACK_RNE_EN for round-to-nearest-even; otherwise the low half is truncated.
module bf16_round
  import eadd_pkg::*;
(
  input  logic [FP32_W-1:0] x,
  output bf16_t             y
);

  logic is_nan;
  logic round_up;

  assign is_nan = (&x[30:23]) & (|x[22:0]);

`ifdef EADD_PACK_RNE_EN
  // A carry out of the mantissa walks into the exponent, so 7F7FFFFF becomes +inf.
  assign round_up = x[15] & ((|x[14:0]) | x[16]);
`else
  assign round_up = 1'b0;
`endif

  assign y = is_nan ? {x[31], 8'hFF, BF16_QNAN_MANT}
                    : x[31:16] + {{(BF16_W-1){1'b0}}, round_up};

endmodule

// File: rtl/eadd_result_pack.sv
// Rounds adder fp32 result beats to bf16, buffers them and streams them out with stage framing.
// Rounding mode is selected by the EADD_PACK_RNE_EN macro (see bf16_round).
module eadd_result_pack
  import eadd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int BEATS_PER_STAGE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stage_start,
  input  logic                          s_tvalid,
  input  logic [LANES*FP32_W-1:0]       s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [LANES*BF16_W-1:0]       m_tdata,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (BEATS_PER_STAGE > 1) ? $clog2(BEATS_PER_STAGE) : 1;
  localparam int DW = LANES * BF16_W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_STAGE - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);

  logic          stage_start_q;
  logic          flush;
  logic          capture;
  logic          rnd_valid;
  logic [DW-1:0] rnd_data;
  logic [DW-1:0] rnd_next;

  logic [DW:0]   mem [FIFO_DEPTH];
  logic [DW:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] beat_cnt;
  logic          ovf_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bf16_round u_round (
      .x (s_tdata[i*FP32_W +: FP32_W]),
      .y (rnd_next[i*BF16_W +: BF16_W])
    );
  end

  assign flush   = stage_start & ~stage_start_q;
  assign capture = s_tvalid & stage_start & ~flush;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_L);
  assign pop   = ~empty & m_tready;
  // The adder cannot be stalled: a full FIFO only accepts when a pop frees a slot this cycle.
  assign push  = rnd_valid & (~full | pop) & ~flush;
  assign drop  = rnd_valid & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_start_q <= 1'b0;
      rnd_valid     <= 1'b0;
      rnd_data      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      beat_cnt      <= '0;
      ovf_q         <= 1'b0;
    end else begin
      stage_start_q <= stage_start;
      if (flush) begin
        rnd_valid <= 1'b0;
        rnd_data  <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        beat_cnt  <= '0;
        ovf_q     <= 1'b0;
      end else begin
        rnd_valid <= capture;
        if (capture)
          rnd_data <= rnd_next;
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
        if (drop)
          ovf_q <= 1'b1;
      end
    end
  end

  // Storage has no reset; the pointers and count alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {(beat_cnt == LAST_BEAT), rnd_data};
  end

  assign head     = mem[rd_ptr];
  assign m_tvalid = ~empty;
  assign m_tdata  = empty ? '0 : head[DW-1:0];
  assign m_tlast  = empty ? 1'b0 : head[DW];
  assign level    = count;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_eadd_result_pack.sv
// Bench for eadd_result_pack: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_eadd_result_pack;

  localparam int FIFO_DEPTH      = 4;
  localparam int BEATS_PER_STAGE = 16;
  localparam int LW              = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stage_start = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [127:0]  s_tdata = '0;
  logic          m_tready = 1'b0;
  logic          m_tvalid;
  logic [63:0]   m_tdata;
  logic          m_tlast;
  logic [LW-1:0] level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eadd_result_pack #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .BEATS_PER_STAGE (BEATS_PER_STAGE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stage_start (stage_start),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .level       (level),
    .overflow    (overflow)
  );

  // Reference conversion from field values with plain arithmetic.
  function automatic logic [15:0] roundModel(input logic [31:0] x);
    int unsigned expo  = (x >> 23) & 32'hFF;
    int unsigned mant  = x & 32'h7F_FFFF;
    int unsigned upper = x >> 16;
    int unsigned lower = x & 32'hFFFF;
    if (expo == 255 && mant != 0)
      return 16'((x >> 31) * 32'h8000 + 32'h7FC0);
`ifdef EADD_PACK_RNE_EN
    if (lower > 32'h8000 || (lower == 32'h8000 && (upper % 2) == 1))
      upper = upper + 1;
`endif
    return 16'(upper);
  endfunction

  function automatic logic [63:0] packModel(input logic [127:0] d);
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[16*i +: 16] = roundModel(d[32*i +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] randLane();
    case ($urandom_range(0, 7))
      0:       return $urandom | 32'h7F80_0001;
      1:       return {1'($urandom_range(0, 1)), 31'h7F80_0000};
      2:       return {16'($urandom), 16'h8000};
      3:       return 32'h7F7F_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [127:0] randBeat();
    return {randLane(), randLane(), randLane(), randLane()};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then return just after the rising edge.
  task automatic applyStimulus(input logic r, input logic ss, input logic v,
                               input logic [127:0] d, input logic rdy);
    @(negedge clk);
    rst         = r;
    stage_start = ss;
    s_tvalid    = v;
    s_tdata     = d;
    m_tready    = rdy;
    @(posedge clk);
    #2;
  endtask

  // Reference model: one pending rounded beat, a bounded queue, a beat counter, a sticky flag.
  logic [64:0] mq[$];
  logic        mPendV  = 1'b0;
  logic [63:0] mPendD  = '0;
  int          mCnt    = 0;
  logic        mOvf    = 1'b0;
  logic        mSsQ    = 1'b0;
  logic        mFlush;
  logic        mPop;
  logic [64:0] mHead;

  always @(posedge clk) begin
    mFlush = stage_start && !mSsQ;
    mPop   = (mq.size() > 0) && m_tready;
    if (rst) begin
      mq.delete();
      mPendV = 1'b0;
      mCnt   = 0;
      mOvf   = 1'b0;
      mSsQ   = 1'b0;
    end else begin
      if (mFlush) begin
        mq.delete();
        mPendV = 1'b0;
        mCnt   = 0;
        mOvf   = 1'b0;
      end else begin
        if (mPop)
          void'(mq.pop_front());
        if (mPendV) begin
          if (mq.size() < FIFO_DEPTH) begin
            mq.push_back({(mCnt == BEATS_PER_STAGE - 1), mPendD});
            mCnt = (mCnt + 1) % BEATS_PER_STAGE;
          end else begin
            mOvf = 1'b1;
          end
        end
        mPendV = s_tvalid && stage_start;
        mPendD = packModel(s_tdata);
      end
      mSsQ = stage_start;
    end
    #1;
    mHead = (mq.size() > 0) ? mq[0] : 65'd0;
    checkOutput("model m_tvalid", 64'(m_tvalid), 64'(mq.size() > 0));
    checkOutput("model m_tdata", m_tdata, mHead[63:0]);
    checkOutput("model m_tlast", 64'(m_tlast), 64'(mHead[64]));
    checkOutput("model level", 64'(level), 64'(mq.size()));
    checkOutput("model overflow", 64'(overflow), 64'(mOvf));
  end

  // Sends 17 beats with ready high; the stage counter must already be at 0.
  task automatic framingCheck(input string tag);
    int   outs     = 0;
    int   lastHits = 0;
    logic tl16     = 1'b0;
    logic tl17     = 1'b1;
    for (int k = 0; k < 21; k++) begin
      applyStimulus(1'b0, 1'b1, (k < 17), randBeat(), 1'b1);
      if (m_tvalid) begin
        outs++;
        if (m_tlast) lastHits++;
        if (outs == 16) tl16 = m_tlast;
        if (outs == 17) tl17 = m_tlast;
      end
    end
    checkOutput({tag, " output count"}, 64'(outs), 64'd17);
    checkOutput({tag, " tlast count"}, 64'(lastHits), 64'd1);
    checkOutput({tag, " tlast on 16"}, 64'(tl16), 64'd1);
    checkOutput({tag, " tlast on 17"}, 64'(tl17), 64'd0);
  endtask

  logic [127:0] beat;
  logic [127:0] ob [6];
  logic [127:0] beatY;

  initial begin
    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset m_tdata", m_tdata, 64'd0);
    checkOutput("reset level", 64'(level), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);

    // Basic: stage start, then one beat, visible two cycles after presentation
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    beat = {32'h0000_0000, 32'hC000_0000, 32'h4049_0FDB, 32'h3F80_0000};
    applyStimulus(1'b0, 1'b1, 1'b1, beat, 1'b1);
    checkOutput("basic not yet valid", 64'(m_tvalid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("basic valid", 64'(m_tvalid), 64'd1);
    checkOutput("basic data", m_tdata, 64'h0000_C000_4049_3F80);

    // Rounding vectors, back to back
    applyStimulus(1'b0, 1'b1, 1'b1, {32'h7F7F_FFFF, 32'h3F80_8001, 32'h3F81_8000, 32'h3F80_8000}, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, {32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0001}, 1'b1);
`ifdef EADD_PACK_RNE_EN
    checkOutput("round rne", m_tdata, 64'h7F80_3F81_3F82_3F80);
`else
    checkOutput("round trunc", m_tdata, 64'h7F7F_3F80_3F81_3F80);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("round nan inf zero", m_tdata, 64'h0000_8000_7F80_7FC0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);

    // Overflow: six beats into a four-deep FIFO with no ready
    for (int k = 0; k < 6; k++) begin
      ob[k] = randBeat();
      applyStimulus(1'b0, 1'b1, 1'b1, ob[k], 1'b0);
      if (k == 4) checkOutput("ovf clear before 5th write", 64'(overflow), 64'd0);
      if (k == 5) checkOutput("ovf set on 5th write", 64'(overflow), 64'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("ovf level full", 64'(level), 64'(FIFO_DEPTH));
    checkOutput("ovf head beat 1", m_tdata, packModel(ob[0]));
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("ovf drain order", m_tdata, packModel(ob[k]));
      checkOutput("ovf sticky", 64'(overflow), 64'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("ovf drained empty", 64'(m_tvalid), 64'd0);

    // Flush: three buffered beats, stage_start low one cycle, then high with a beat
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b1, 1'b1, randBeat(), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("flush pre level", 64'(level), 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, randBeat(), 1'b0);
    checkOutput("flush m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("flush level", 64'(level), 64'd0);
    checkOutput("flush overflow", 64'(overflow), 64'd0);
    beatY = randBeat();
    applyStimulus(1'b0, 1'b1, 1'b1, beatY, 1'b0);
    checkOutput("flush dropped beat", 64'(m_tvalid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("post flush valid", 64'(m_tvalid), 64'd1);
    checkOutput("post flush data", m_tdata, packModel(beatY));
    checkOutput("post flush level", 64'(level), 64'd1);

    // Framing after a fresh stage
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    framingCheck("frame");

    // Reset mid-stream with two beats queued
    applyStimulus(1'b0, 1'b1, 1'b1, randBeat(), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, randBeat(), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, randBeat(), 1'b0);
    checkOutput("rst m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst m_tdata", m_tdata, 64'd0);
    checkOutput("rst m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst level", 64'(level), 64'd0);
    checkOutput("rst overflow", 64'(overflow), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    framingCheck("frame after rst");

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 600; k++)
      applyStimulus(($urandom_range(0, 249) == 0), ($urandom_range(0, 29) != 0),
                    ($urandom_range(0, 3) != 0), randBeat(), ($urandom_range(0, 2) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
